// File: rtl/vram_wq_pkg.sv
// Shared definitions for the VRAM posted-write queue.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package vram_wq_pkg;

  // Default geometry of the host/VRAM word path.
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  // Drain FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } drain_st_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an exported fill level; head entry is visible combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty; full/empty are exported.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   push, push_dat   write one entry
//   pop              retire the head entry
//   head_dat         current head entry
//   level            number of stored entries, 0..DEPTH
//   empty, full      level == 0 / level == DEPTH
module sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; level qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);

endmodule

// File: rtl/vram_write_queue.sv
// Posted host-write buffer that drains into VRAM only while scanout leaves the memory free.
// Latency: host_done one cycle after accept; vram_cs two cycles after accept when empty and the window is open.
// Backpressure: host_cs is held without acknowledge while the FIFO is full; VRAM writes stretch until vram_done.
//
// Ports:
//   pixel_clk, reset              single clock, synchronous active-high reset
//   host_cs/addr/data, host_done  held write request and its one-cycle acknowledge
//   host_write_avail, level       registered free-space flag and current fill level
//   vblank, hblank                scanout blanking; hblank matters only with VRAM_WQ_HBLANK_DRAIN_EN
//   vram_cs/we/addr/wdata, vram_done  VRAM write port and its completion strobe
// Build option: define VRAM_WQ_HBLANK_DRAIN_EN to also drain during horizontal blanking.
module vram_write_queue
  import vram_wq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                     pixel_clk,
  input  logic                     reset,
  input  logic                     host_cs,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic [DATA_W-1:0]        host_data,
  output logic                     host_done,
  output logic                     host_write_avail,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     vblank,
  input  logic                     hblank,
  output logic                     vram_cs,
  output logic                     vram_we,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_wdata,
  input  logic                     vram_done
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic                     acked;
  logic                     accept;
  logic                     pop;
  logic                     window;
  logic                     empty;
  logic                     full;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [LW-1:0]            level_nxt;
  drain_st_t                state;

`ifdef VRAM_WQ_HBLANK_DRAIN_EN
  assign window = vblank || hblank;
`else
  logic unused_hblank;
  assign unused_hblank = hblank;
  assign window        = vblank;
`endif

  // acked blocks a still-held request from being pushed a second time.
  assign accept = host_cs && !acked && !full;
  // The head retires on the same edge the VRAM reports completion.
  assign pop    = (state == ST_WRITE) && vram_done;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (pixel_clk),
    .reset    (reset),
    .push     (accept),
    .push_dat ({host_addr, host_data}),
    .pop      (pop),
    .head_dat (head),
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  // Fill level after this edge, so host_write_avail tracks level without lag.
  always_comb begin
    level_nxt = level;
    if (accept && !pop)      level_nxt = level + LW'(1);
    else if (!accept && pop) level_nxt = level - LW'(1);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      acked            <= 1'b0;
      host_done        <= 1'b0;
      host_write_avail <= 1'b1;
    end else begin
      host_done        <= accept;
      host_write_avail <= (level_nxt != FULL_LVL);
      if (!host_cs)    acked <= 1'b0;
      else if (accept) acked <= 1'b1;
    end
  end

  // Drain FSM: a started write runs to vram_done regardless of the window.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vram_cs    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (window && !empty) begin
            state                   <= ST_WRITE;
            vram_cs                 <= 1'b1;
            {vram_addr, vram_wdata} <= head;
          end
        end
        ST_WRITE: begin
          if (vram_done) begin
            state   <= ST_IDLE;
            vram_cs <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          vram_cs <= 1'b0;
        end
      endcase
    end
  end

  assign vram_we = vram_cs;

endmodule
